// File: rtl/bus_uart_if.sv
// Word-addressed CPU bus as seen by the UART slave: one store/read port with byte strobes.
interface bus_uart_if;
  logic [29:0] bus_addr;
  logic [31:0] bus_data_w;
  logic [3:0]  bus_mask_w;
  logic [31:0] bus_data_r;
  logic        sel;

  modport master (output bus_addr, bus_data_w, bus_mask_w, input bus_data_r, sel);
  modport slave  (input bus_addr, bus_data_w, bus_mask_w, output bus_data_r, sel);
endinterface

// File: rtl/bus_uart.sv
// Memory-mapped UART: DATA/STATUS register pair, TX FIFO drained by a bit-serial transmitter.
// Optional receiver enabled by defining UART_RX_EN.
module bus_uart #(
  parameter logic [29:0] BASE      = 30'h3FFF_FFFE,
  parameter int          CLK_DIV   = 16,
  parameter int          FIFO_LOG2 = 2
) (
  input  logic      clock,
  input  logic      reset,
`ifdef UART_RX_EN
  input  logic      rx,
`endif
  bus_uart_if.slave bus,
  output logic      tx
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int PTR_W = FIFO_LOG2 + 1;
  localparam int DIV_W = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic             wr_data, wr_status;
  logic [5:0]       clr;
  logic             rx_valid, rx_overrun, rx_frame_err;
  logic [7:0]       rx_byte;
  logic             tx_drop, tx_full, tx_idle;
  logic             unused;

  assign bus.sel   = (bus.bus_addr[29:1] == BASE[29:1]);
  assign wr_data   = bus.sel && bus.bus_mask_w[0] && !bus.bus_addr[0];
  assign wr_status = bus.sel && bus.bus_mask_w[0] && bus.bus_addr[0];
  assign clr       = wr_status ? bus.bus_data_w[5:0] : 6'd0;
  assign unused    = ^{bus.bus_data_w[31:8], bus.bus_mask_w[3:1], clr[1:0]};

  always_comb begin
    bus.bus_data_r = 32'd0;
    if (bus.sel)
      bus.bus_data_r = bus.bus_addr[0]
        ? {26'd0, rx_frame_err, tx_drop, rx_overrun, rx_valid, tx_idle, tx_full}
        : {24'd0, rx_byte};
  end

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic             empty, push, pop;

  // A push into a full FIFO is still taken when the transmitter pops on the same edge.
  assign empty   = (head == tail);
  assign tx_full = (head[FIFO_LOG2] != tail[FIFO_LOG2]) &&
                   (head[FIFO_LOG2-1:0] == tail[FIFO_LOG2-1:0]);
  assign push    = wr_data && (!tx_full || pop);

  always_ff @(posedge clock)
    if (push) mem[tail[FIFO_LOG2-1:0]] <= bus.bus_data_w[7:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      tx_drop <= 1'b0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      tx_drop <= (wr_data && !push) || (tx_drop && !clr[4]);
    end
  end

  tx_state_t        state, state_nxt;
  logic [DIV_W-1:0] div;
  logic [2:0]       idx;
  logic [7:0]       shifter;
  logic             bit_end;

  assign bit_end = (div == DIV_W'(CLK_DIV - 1));
  assign tx_idle = empty && (state == IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!empty) state_nxt = START;
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && idx == 3'd7) state_nxt = STOP;
      STOP:  if (bit_end) state_nxt = empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx  = 1'b1;
    pop = 1'b0;
    case (state)
      IDLE:  pop = !empty;
      START: tx  = 1'b0;
      DATA:  tx  = shifter[0];
      STOP:  pop = bit_end && !empty;
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div <= '0;
      idx <= '0;
    end else begin
      if (state == IDLE || bit_end) div <= '0;
      else                          div <= div + 1'b1;
      if (state == DATA && bit_end) idx <= idx + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (pop)                           shifter <= mem[head[FIFO_LOG2-1:0]];
    else if (state == DATA && bit_end) shifter <= {1'b0, shifter[7:1]};
  end

`ifdef UART_RX_EN
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t        rx_state, rx_state_nxt;
  logic             rx_s1, rx_s2;
  logic [DIV_W-1:0] rdiv;
  logic [2:0]       ridx;
  logic [7:0]       rshift;
  logic             half_end, rbit_end, sample_bit, stop_ok, stop_bad;

  assign half_end = (rdiv == DIV_W'(CLK_DIV / 2 - 1));
  assign rbit_end = (rdiv == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) rx_state <= R_IDLE;
    else       rx_state <= rx_state_nxt;
  end

  // The start bit is re-checked mid-bit so short glitches fall back to idle.
  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      R_IDLE:  if (!rx_s2) rx_state_nxt = R_START;
      R_START: if (half_end) rx_state_nxt = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (rbit_end && ridx == 3'd7) rx_state_nxt = R_STOP;
      R_STOP:  if (rbit_end) rx_state_nxt = R_IDLE;
      default: rx_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    sample_bit = (rx_state == R_DATA) && rbit_end;
    stop_ok    = (rx_state == R_STOP) && rbit_end && rx_s2;
    stop_bad   = (rx_state == R_STOP) && rbit_end && !rx_s2;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rdiv         <= '0;
      ridx         <= '0;
      rx_byte      <= 8'd0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      if (rx_state == R_IDLE || rx_state != rx_state_nxt || rbit_end) rdiv <= '0;
      else                                                            rdiv <= rdiv + 1'b1;
      if (sample_bit) ridx <= ridx + 3'd1;
      if (stop_ok)    rx_byte <= rshift;
      rx_valid     <= stop_ok || (rx_valid && !clr[2]);
      rx_overrun   <= (stop_ok && rx_valid) || (rx_overrun && !clr[3]);
      rx_frame_err <= stop_bad || (rx_frame_err && !clr[5]);
    end
  end

  always_ff @(posedge clock)
    if (sample_bit) rshift <= {rx_s2, rshift[7:1]};
`else
  logic unused_rx;
  assign rx_valid     = 1'b0;
  assign rx_overrun   = 1'b0;
  assign rx_frame_err = 1'b0;
  assign rx_byte      = 8'd0;
  assign unused_rx    = ^{clr[5], clr[3:2]};
`endif

endmodule

// File: tb/tb_bus_uart.sv
// Randomized scoreboard bench for bus_uart: a frame-level model predicts TX frames and STATUS.
module tb_bus_uart;
  localparam logic [29:0] BASE  = 30'h3FFF_FFFE;
  localparam logic [29:0] STAT  = BASE + 30'd1;
  localparam int          CD    = 4;
  localparam int          FL    = 2;
  localparam int          DEPTH = 1 << FL;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic tx;
`ifdef UART_RX_EN
  logic rx;
`endif

  bus_uart_if bif();

  bus_uart #(.BASE(BASE), .CLK_DIV(CD), .FIFO_LOG2(FL)) dut (
    .clock(clock),
    .reset(reset),
`ifdef UART_RX_EN
    .rx(rx),
`endif
    .bus(bif),
    .tx(tx)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int frames = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: bytes waiting in the FIFO, cycles left in the frame on the wire,
  // and the sticky flags. A frame lasts 10*CD cycles; a new one starts the moment the
  // line is free and a byte is waiting.
  logic [7:0] m_q[$];
  exp_t       sb[$];
  int         m_r = 0;
  bit         m_drop = 0, m_valid = 0, m_ovr = 0, m_ferr = 0;
  logic [7:0] m_rxbyte = 8'd0;
  bit         mw_d, mw_s, m_pop, m_push;
  logic [5:0] m_clr;
  exp_t       m_e;

  always @(posedge clock) begin
    if (reset) begin
      m_q.delete();
      sb.delete();
      m_r = 0;
      m_drop = 0; m_valid = 0; m_ovr = 0; m_ferr = 0;
      m_rxbyte = 8'd0;
    end else begin
      mw_d   = bif.bus_mask_w[0] && (bif.bus_addr == BASE);
      mw_s   = bif.bus_mask_w[0] && (bif.bus_addr == STAT);
      m_clr  = mw_s ? bif.bus_data_w[5:0] : 6'd0;
      m_pop  = (m_r <= 1) && (m_q.size() > 0);
      m_push = mw_d && ((m_q.size() < DEPTH) || m_pop);
      if (m_pop) begin
        m_e.data  = m_q.pop_front();
        m_e.start = cyc + 1;
        sb.push_back(m_e);
        m_r = 10 * CD;
      end else if (m_r > 0) begin
        m_r--;
      end
      if (m_push) m_q.push_back(bif.bus_data_w[7:0]);
      m_drop = (mw_d && !m_push) || (m_drop && !m_clr[4]);
      if (m_clr[2]) m_valid = 0;
      if (m_clr[3]) m_ovr = 0;
      if (m_clr[5]) m_ferr = 0;
    end
  end

  function automatic logic [31:0] exp_status();
    return {26'd0, m_ferr, m_drop, m_ovr, m_valid,
            (m_q.size() == 0 && m_r == 0), (m_q.size() == DEPTH)};
  endfunction

  // Monitor: decode each frame on tx mid-bit and compare against the scoreboard.
  initial begin : monitor
    exp_t       e;
    logic [7:0] got;
    int         s;
    bit         abort, have;
    forever begin
      @(negedge clock);
      if (!reset && tx === 1'b0) begin
        s = cyc; abort = 0; got = 8'd0; have = 0;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_frame: unexpected frame at cycle %0d, expected none", s);
        end else begin
          e = sb.pop_front();
          have = 1;
        end
        for (int j = 1; j <= 9*CD + CD/2 && !abort; j++) begin
          @(negedge clock);
          if (reset) abort = 1;
          else if (j == CD/2) check("tx_start_bit", 32'(tx), 32'd0);
          else if (j < 9*CD && (j % CD) == CD/2) got = {tx, got[7:1]};
          else if (j == 9*CD + CD/2) check("tx_stop_bit", 32'(tx), 32'd1);
        end
        if (!abort && have) begin
          check("tx_frame_data", 32'(got), 32'(e.data));
          check("tx_frame_start", s, e.start);
          frames++;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    bif.bus_addr   = a;
    bif.bus_data_w = d;
    bif.bus_mask_w = 4'b0001;
    @(posedge clock); #1;
    bif.bus_mask_w = 4'b0000;
  endtask

  task automatic rd(input logic [29:0] a, output logic [31:0] d);
    bif.bus_addr   = a;
    bif.bus_mask_w = 4'b0000;
    #1;
    d = bif.bus_data_r;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clock);
      #1;
    end
  endtask

  task automatic chk_status(input string name);
    logic [31:0] d;
    rd(STAT, d);
    check(name, d, exp_status());
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((m_q.size() != 0 || m_r != 0) && n < 4000) begin
      @(posedge clock); #1;
      n++;
    end
    idle(2);
    check(name, sb.size(), 0);
  endtask

`ifdef UART_RX_EN
  task automatic send_rx(input logic [7:0] b, input bit stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (CD) @(posedge clock);
      #1;
    end
    rx = 1'b1;
    idle(2 * CD);
    if (stop) begin
      m_ovr    = m_ovr | m_valid;
      m_valid  = 1;
      m_rxbyte = b;
    end else begin
      m_ferr = 1;
    end
  endtask
`endif

  initial begin : main
    logic [31:0] d;
    logic [29:0] a;
    int          n, f0, op;
    bit          done;
    logic [7:0]  b;

    bif.bus_addr   = 30'd0;
    bif.bus_data_w = 32'd0;
    bif.bus_mask_w = 4'd0;
    reset = 1'b1;
`ifdef UART_RX_EN
    rx = 1'b1;
`endif
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    check("reset_tx", 32'(tx), 32'd1);
    rd(STAT, d);  check("reset_status", d, 32'h2);
    rd(BASE, d);  check("reset_data", d, 32'h0);
    check("sel_in_range", 32'(bif.sel), 32'd1);
    rd(30'h0000_1234, d);
    check("unsel_data", d, 32'h0);
    check("unsel_sel", 32'(bif.sel), 32'd0);
    rd(BASE - 30'd1, d);
    check("below_base_data", d, 32'h0);
    check("below_base_sel", 32'(bif.sel), 32'd0);

    // Single frame and the cycle on which the transmitter reports idle again.
    wr(BASE, 32'h55);
    n = 0; done = 0;
    while (!done && n < 200) begin
      @(posedge clock); #1;
      n++;
      rd(STAT, d);
      done = d[1];
    end
    check("tx_idle_latency", n, 10*CD + 1);
    chk_status("status_after_0x55");

    // Five stores while the first byte is on the wire: no drop, back-to-back frames.
    f0 = frames;
    for (int i = 1; i <= 5; i++) wr(BASE, 32'(i));
    chk_status("status_fifo_full");
    wait_drain("drain_five");
    check("frames_five", frames - f0, 5);
    rd(STAT, d); check("no_drop_five", 32'(d[4]), 32'd0);

    // Six stores from idle: one popped at once, four queued, one dropped.
    f0 = frames;
    for (int i = 0; i < 6; i++) wr(BASE, 32'h11 + 32'(i));
    rd(STAT, d); check("drop_set", 32'(d[4]), 32'd1);
    chk_status("status_after_six");
    wait_drain("drain_six");
    check("frames_six", frames - f0, 5);
    wr(STAT, 32'h10);
    rd(STAT, d); check("drop_cleared", d, 32'h2);
    wr(STAT, 32'h3);
    chk_status("status_ro_bits");

`ifdef UART_RX_EN
    send_rx(8'hA3, 1'b1);
    chk_status("rx_status_a3");
    rd(BASE, d); check("rx_data_a3", d, 32'hA3);
    send_rx(8'h3C, 1'b1);
    rd(BASE, d); check("rx_data_3c", d, 32'h3C);
    rd(STAT, d); check("rx_overrun_set", 32'(d[3:2]), 32'h3);
    wr(STAT, 32'h0C);
    rd(STAT, d); check("rx_flags_cleared", 32'(d[3:2]), 32'h0);
    b = 8'($urandom);
    send_rx(b, 1'b1);
    send_rx(8'($urandom), 1'b0);
    rd(STAT, d); check("rx_frame_err", 32'(d[5]), 32'd1);
    chk_status("rx_status_ferr");
    rd(BASE, d); check("rx_data_kept", d, 32'(b));
    rx = 1'b0;
    @(posedge clock); #1;
    rx = 1'b1;
    idle(30);
    chk_status("rx_glitch");
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'($urandom_range(0, 3) != 0));
      chk_status("rx_status_random");
      rd(BASE, d); check("rx_data_random", d, 32'(m_rxbyte));
    end
    wr(STAT, 32'h3C);
    chk_status("rx_clear_all");
`endif

    // Reset in the middle of a frame: line returns high and queued bytes vanish.
    for (int i = 0; i < 3; i++) wr(BASE, 32'($urandom_range(0, 255)));
    idle(3 * CD);
    reset = 1'b1;
    @(posedge clock); #1;
    check("tx_after_reset", 32'(tx), 32'd1);
    rd(STAT, d); check("status_in_reset", d, 32'h2);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (tx !== 1'b1) n++;
    end
    check("no_residual_frame", n, 0);
    chk_status("status_after_reset");

    // Random traffic.
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 9);
      if (op < 6) begin
        wr(BASE, 32'($urandom_range(0, 255)));
        idle($urandom_range(0, 3));
      end else if (op == 6) begin
        wr(STAT, 32'($urandom_range(0, 63)));
      end else if (op < 9) begin
        idle($urandom_range(1, 50));
        chk_status("status_random");
      end else begin
        a = 30'($urandom);
        if (a[29:1] == BASE[29:1]) a = a ^ 30'h4;
        rd(a, d);
        check("rand_unsel_data", d, 32'h0);
        check("rand_unsel_sel", 32'(bif.sel), 32'd0);
        rd(BASE, d);
        check("rand_data_read", d, 32'(m_rxbyte));
      end
    end
    wait_drain("drain_random");
    chk_status("status_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_uart.md
# bus_uart

Memory-mapped UART slave on the CPU's single word-addressed bus; it sits directly downstream of the core alongside RAM, in the bus decode. CPU stores to its data register queue bytes in a transmit FIFO that a bit-serial transmitter drains at a fixed baud divider. An optional receiver latches one incoming byte. Reads are combinational and side-effect free, so the core's same-cycle read timing is honoured.

## Interface
- BASE, 30'h3FFF_FFFE: word address of the register pair; must be even.
- CLK_DIV, 16: clock cycles per serial bit; minimum 4.
- FIFO_LOG2, 2: TX FIFO depth is 2**FIFO_LOG2 entries.
- clock  in  1  clock; all state on posedge.
- reset  in  1  reset, synchronous, active-high.
- bus_addr  in  30  word address from the core.
- bus_data_w  in  32  store data; the byte is taken from bits [7:0].
- bus_mask_w  in  4  byte write strobes; a write occurs when bit 0 is set.
- bus_data_r  out  32  read data; 0 when not selected.
- sel  out  1  high when bus_addr[29:1] == BASE[29:1]; used by the bus read mux.
- tx  out  1  serial output, idle high.
- rx  in  1  serial input; present only with UART_RX_EN.

## Operation
- Register map, word offset = bus_addr[0]:
  - Offset 0, DATA: a write enqueues bus_data_w[7:0]. A read returns {24'b0, rx_byte}.
  - Offset 1, STATUS, read: bit0 tx_full, bit1 tx_idle (FIFO empty and shifter in IDLE), bit2 rx_valid, bit3 rx_overrun, bit4 tx_drop, bit5 rx_frame_err; bits [31:6] are 0.
  - Offset 1, STATUS, write: write-1-to-clear on bits [5:2]; bits 0 and 1 are ignored.
- Write to DATA when the FIFO is full: the byte is discarded and tx_drop is set.
- Sticky bits: if a set and a clear land on the same edge, the set wins.
- bus_data_r is combinational from bus_addr and current state; no read has a side effect.
- TX FIFO: circular with head/tail pointers FIFO_LOG2+1 bits wide; full and empty are decided by the MSB compare. Simultaneous push and pop on a full FIFO: the push is accepted.
- TX FSM states, one bit period = CLK_DIV cycles counted by a divider:
  - IDLE: tx=1. On FIFO non-empty, pop the head into an 8-bit shift register and go to START.
  - START: tx=0 for one bit period, then go to DATA.
  - DATA: shifts out 8 bits LSB first, one bit period each, tracked by a 3-bit index, then go to STOP.
  - STOP: tx=1 for one bit period. At the end, if the FIFO is non-empty, pop and go to START with no gap; otherwise go to IDLE.
- RX path (UART_RX_EN):
  - rx passes through a 2-flop synchronizer.
  - Start detection: a low level in R_IDLE starts the frame. The start bit is re-sampled at CLK_DIV/2; if it is high, return to R_IDLE.
  - 8 data bits are then sampled every CLK_DIV, followed by the stop bit.
  - Stop bit = 1: rx_byte is loaded and rx_valid set. If rx_valid was already set, the new byte overwrites and rx_overrun is set.
  - Stop bit = 0: the byte is discarded and rx_frame_err is set.
  - Return to R_IDLE after the stop sample.

## Timing
- Reset values: tx=1, bus_data_r=0 when unselected, FIFO empty, TX FSM in IDLE, divider 0, all sticky bits 0, rx_byte=0, RX FSM in R_IDLE.
- The core holds bus_mask_w non-zero for exactly one cycle per store, so each store produces exactly one enqueue.
- First byte: DATA write at edge N with the FIFO empty and FSM idle. The FIFO is non-empty after N, the pop happens at N+1, and tx goes low after N+1.
- A frame is exactly 10*CLK_DIV cycles. Back-to-back frames have no idle cycles between the stop bit and the next start bit.
- tx_idle goes high on the edge that enters IDLE.
- RX latency: rx_valid rises 2 (synchronizer) + 9.5*CLK_DIV cycles after the falling edge on rx, ±1 cycle of sampling uncertainty.
- Reset mid-frame aborts: tx=1 on the next cycle and the FIFO contents are lost.

## Configuration
- UART_RX_EN defined: the rx port, synchronizer, RX FSM, rx_byte and STATUS bits 2, 3 and 5 are implemented.
- UART_RX_EN undefined: no rx port, DATA reads return 0, STATUS bits 2, 3 and 5 read 0 and their clears are ignored.

## Test plan
- Reset with CLK_DIV=4, write 0x55 to DATA -> tx low after the next edge, then bits 1,0,1,0,1,0,1,0 LSB first, then high; 40 cycles total; tx_idle=1 afterwards.
- FIFO_LOG2=2, five writes 0x01–0x05 in consecutive store cycles while the first byte is being sent -> all five frames back-to-back with no gap, tx_drop=0. Then six writes while idle -> tx_drop=1 and five frames sent (one popped immediately, so one write dropped). Writing 0x10 to STATUS -> tx_drop=0.
- Read STATUS right after reset -> 0x00000002. Read with bus_addr outside BASE..BASE+1 -> sel=0, bus_data_r=0.
- UART_RX_EN, drive frame 0xA3 on rx at CLK_DIV=4 -> rx_valid=1 and DATA reads 0x000000A3. A second frame 0x3C without clearing -> DATA=0x3C, rx_overrun=1. Writing 0x0C to STATUS clears both bits.
- UART_RX_EN, frame with stop bit 0 -> rx_frame_err=1, rx_valid unchanged. A 1-cycle low glitch on rx -> no status change.
- Assert reset during the DATA bits of a frame -> tx=1 next cycle, STATUS=0x2 and no residual frame after deassert.
